// File: rtl/tsp_status_display.sv
// Board status monitor: debounced window/mode buttons select which LED-wide slice
// of the TSP status word drives the LEDs, in live, hold, heartbeat or sticky-OR form.
module tsp_status_display #(
    parameter int unsigned STATUS_W        = 32,
    parameter int unsigned LED_W           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HEARTBEAT_DIV   = 50000000,
    localparam int unsigned N_WIN          = (STATUS_W + LED_W - 1) / LED_W,
    localparam int unsigned WSEL_W         = (N_WIN > 1) ? $clog2(N_WIN) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_win,
    input  logic                btn_mode,
    input  logic [STATUS_W-1:0] status_in,
    input  logic                status_valid,
    output logic [LED_W-1:0]    led,
    output logic [WSEL_W-1:0]   win_sel,
    output logic [1:0]          mode
);

    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HB_W  = $clog2(HEARTBEAT_DIV);
    localparam int unsigned PAD_W = N_WIN * LED_W;

    localparam logic [DB_W-1:0]   DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HB_W-1:0]   HB_MAX  = HB_W'(HEARTBEAT_DIV - 1);
    localparam logic [WSEL_W-1:0] WIN_MAX = WSEL_W'(N_WIN - 1);

    typedef enum logic [1:0] {
        MODE_LIVE   = 2'd0,
        MODE_HOLD   = 2'd1,
        MODE_HEART  = 2'd2,
        MODE_STICKY = 2'd3
    } mode_e;

    // Index 0 is the window button, index 1 the mode button.
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      stable;
    logic [DB_W-1:0] db_cnt [2];
    logic [1:0]      press_c;

    mode_e                mode_q;
    mode_e                mode_d;
    logic [WSEL_W-1:0]    win_q;
    logic [HB_W-1:0]      hb_cnt;
    logic                 hb;
    logic [STATUS_W-1:0]  snap;
    logic [STATUS_W-1:0]  acc;
    logic [LED_W-1:0]     led_d;
    logic [LED_W-1:0]     snap_win;
    logic [LED_W-1:0]     acc_win;

    // Two-FF synchronizers followed by per-button stability counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {btn_mode, btn_win};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == DB_MAX) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Press fires in the same cycle stable is about to rise.
    always_comb begin
        press_c = '0;
        for (int i = 0; i < 2; i++) begin
            press_c[i] = sync2[i] & ~stable[i] & (db_cnt[i] == DB_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_LIVE;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (press_c[1]) begin
            case (mode_q)
                MODE_LIVE:   mode_d = MODE_HOLD;
                MODE_HOLD:   mode_d = MODE_HEART;
                MODE_HEART:  mode_d = MODE_STICKY;
                MODE_STICKY: mode_d = MODE_LIVE;
            endcase
        end
    end

    // Zero-pads the source so a partial top window reads high bits as 0.
    function automatic logic [LED_W-1:0] window_of(input logic [STATUS_W-1:0] src,
                                                   input logic [WSEL_W-1:0]   sel);
        logic [PAD_W-1:0] pad;
        logic [PAD_W-1:0] shifted;
        pad       = PAD_W'(src);
        shifted   = pad >> (32'(sel) * LED_W);
        window_of = shifted[LED_W-1:0];
    endfunction

    always_comb begin
        snap_win = window_of(snap, win_q);
        acc_win  = window_of(acc, win_q);
        led_d    = snap_win;
        case (mode_q)
            MODE_HEART: begin
                led_d            = snap_win;
                led_d[LED_W-1]   = hb;
            end
            MODE_STICKY: led_d = acc_win;
            default:     led_d = snap_win;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q  <= '0;
            hb_cnt <= '0;
            hb     <= 1'b0;
            snap   <= '0;
            acc    <= '0;
            led    <= '0;
        end else begin
            if (press_c[0]) begin
                win_q <= (win_q == WIN_MAX) ? '0 : win_q + WSEL_W'(1);
            end

            if (hb_cnt == HB_MAX) begin
                hb_cnt <= '0;
                hb     <= ~hb;
            end else begin
                hb_cnt <= hb_cnt + HB_W'(1);
            end

            if (status_valid && (mode_q != MODE_HOLD)) begin
                snap <= status_in;
            end

            // Entering sticky restarts the accumulation, folding in this cycle's word.
            if ((mode_d == MODE_STICKY) && (mode_q != MODE_STICKY)) begin
                acc <= status_valid ? status_in : '0;
            end else if ((mode_q == MODE_STICKY) && status_valid) begin
                acc <= acc | status_in;
            end

            led <= led_d;
        end
    end

    assign win_sel = win_q;
    assign mode    = mode_q;

endmodule

// File: tb/tb_tsp_status_display.sv
// Directed bench for tsp_status_display: table vectors for window/mode/sticky behaviour
// plus hand sequences for reset-held presses, heartbeat period and a padded narrow status.
module tb_tsp_status_display;

    logic        clk;
    logic        rst;
    logic        btn_win;
    logic        btn_mode;
    logic [31:0] status_in;
    logic        status_valid;
    logic [7:0]  led;
    logic [1:0]  win_sel;
    logic [1:0]  mode;
    logic [7:0]  led2;
    logic [0:0]  win_sel2;
    logic [1:0]  mode2;

    int n_checks = 0;
    int n_fail   = 0;

    tsp_status_display #(
        .STATUS_W(32), .LED_W(8), .DEBOUNCE_CYCLES(4), .HEARTBEAT_DIV(8)
    ) dut (
        .clk(clk), .rst(rst), .btn_win(btn_win), .btn_mode(btn_mode),
        .status_in(status_in), .status_valid(status_valid),
        .led(led), .win_sel(win_sel), .mode(mode)
    );

    tsp_status_display #(
        .STATUS_W(12), .LED_W(8), .DEBOUNCE_CYCLES(4), .HEARTBEAT_DIV(8)
    ) dut_narrow (
        .clk(clk), .rst(rst), .btn_win(btn_win), .btn_mode(btn_mode),
        .status_in(status_in[11:0]), .status_valid(status_valid),
        .led(led2), .win_sel(win_sel2), .mode(mode2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        bw;
        logic        bm;
        logic [31:0] st;
        logic        vld;
        int          cyc;
        logic [7:0]  exp_led;
        logic [7:0]  led_mask;
        logic [1:0]  exp_win;
        logic [1:0]  exp_mode;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic bw, logic bm, logic [31:0] st, logic vld, int cyc,
                                logic [7:0] el, logic [7:0] msk, logic [1:0] ew,
                                logic [1:0] em);
        vec_t v;
        v.bw = bw; v.bm = bm; v.st = st; v.vld = vld; v.cyc = cyc;
        v.exp_led = el; v.led_mask = msk; v.exp_win = ew; v.exp_mode = em;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_range(int lo, int hi);
        for (int i = lo; i < hi; i++) begin
            btn_win      = vq[i].bw;
            btn_mode     = vq[i].bm;
            status_in    = vq[i].st;
            status_valid = vq[i].vld;
            repeat (vq[i].cyc) tick();
            check($sformatf("vec%0d led", i), 32'(led & vq[i].led_mask),
                  32'(vq[i].exp_led & vq[i].led_mask));
            check($sformatf("vec%0d win_sel", i), 32'(win_sel), 32'(vq[i].exp_win));
            check($sformatf("vec%0d mode", i), 32'(mode), 32'(vq[i].exp_mode));
        end
    endtask

    task automatic do_reset();
        btn_win = 1'b0; btn_mode = 1'b0; status_in = '0; status_valid = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    int n_a;
    int n_b;
    logic prev_hb;
    int   since;
    int   toggles;

    initial begin
        // Phase A: latency, window stepping/wrap, glitch rejection.
        vq.push_back(mk(0, 0, 32'hA1B2C3D4, 1, 1,  8'h00, 8'hFF, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1,  8'hD4, 8'hFF, 0, 0));
        vq.push_back(mk(1, 0, 32'h0,        0, 10, 8'hC3, 8'hFF, 1, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 10, 8'hC3, 8'hFF, 1, 0));
        vq.push_back(mk(1, 0, 32'h0,        0, 10, 8'hB2, 8'hFF, 2, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 10, 8'hB2, 8'hFF, 2, 0));
        vq.push_back(mk(1, 0, 32'h0,        0, 10, 8'hA1, 8'hFF, 3, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 10, 8'hA1, 8'hFF, 3, 0));
        vq.push_back(mk(1, 0, 32'h0,        0, 10, 8'hD4, 8'hFF, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 10, 8'hD4, 8'hFF, 0, 0));
        vq.push_back(mk(1, 0, 32'h0,        0, 2,  8'hD4, 8'hFF, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 10, 8'hD4, 8'hFF, 0, 0));
        n_a = vq.size();
        // Phase B: hold, heartbeat, sticky accumulation and re-entry, dual press.
        vq.push_back(mk(0, 0, 32'hA1B2C3D4, 1, 1,  8'h00, 8'hFF, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 1,  8'hD4, 8'hFF, 0, 0));
        vq.push_back(mk(0, 1, 32'h0,        0, 10, 8'hD4, 8'hFF, 0, 1));
        vq.push_back(mk(0, 0, 32'h0,        0, 10, 8'hD4, 8'hFF, 0, 1));
        vq.push_back(mk(0, 0, 32'h000000FF, 1, 3,  8'hD4, 8'hFF, 0, 1));
        vq.push_back(mk(0, 1, 32'h000000FF, 1, 10, 8'h7F, 8'h7F, 0, 2));
        vq.push_back(mk(0, 0, 32'h0,        0, 10, 8'h7F, 8'h7F, 0, 2));
        n_b = vq.size();
        vq.push_back(mk(0, 1, 32'h0,        0, 10, 8'h00, 8'hFF, 0, 3));
        vq.push_back(mk(0, 0, 32'h0,        0, 10, 8'h00, 8'hFF, 0, 3));
        vq.push_back(mk(0, 0, 32'h01,       1, 1,  8'h00, 8'hFF, 0, 3));
        vq.push_back(mk(0, 0, 32'h0,        0, 1,  8'h01, 8'hFF, 0, 3));
        vq.push_back(mk(0, 0, 32'h10,       1, 1,  8'h01, 8'hFF, 0, 3));
        vq.push_back(mk(0, 0, 32'h0,        0, 1,  8'h11, 8'hFF, 0, 3));
        vq.push_back(mk(0, 0, 32'h80,       1, 1,  8'h11, 8'hFF, 0, 3));
        vq.push_back(mk(0, 0, 32'h0,        0, 1,  8'h91, 8'hFF, 0, 3));
        vq.push_back(mk(0, 1, 32'h0,        0, 10, 8'h80, 8'hFF, 0, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 10, 8'h80, 8'hFF, 0, 0));
        vq.push_back(mk(0, 1, 32'h0,        0, 10, 8'h80, 8'hFF, 0, 1));
        vq.push_back(mk(0, 0, 32'h0,        0, 10, 8'h80, 8'hFF, 0, 1));
        vq.push_back(mk(0, 1, 32'h0,        0, 10, 8'h00, 8'h7F, 0, 2));
        vq.push_back(mk(0, 0, 32'h0,        0, 10, 8'h00, 8'h7F, 0, 2));
        vq.push_back(mk(0, 1, 32'h0,        0, 10, 8'h00, 8'hFF, 0, 3));
        vq.push_back(mk(0, 0, 32'h0,        0, 10, 8'h00, 8'hFF, 0, 3));
        vq.push_back(mk(1, 1, 32'h0,        0, 10, 8'h00, 8'hFF, 1, 0));
        vq.push_back(mk(0, 0, 32'h0,        0, 10, 8'h00, 8'hFF, 1, 0));

        do_reset();
        check("reset led", 32'(led), 32'h00);
        check("reset win_sel", 32'(win_sel), 32'h0);
        check("reset mode", 32'(mode), 32'h0);

        run_range(0, n_a);

        // Button already held when reset releases: exactly one window step.
        btn_win = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        check("held-rst before accept", 32'(win_sel), 32'h0);
        tick();
        check("held-rst accept", 32'(win_sel), 32'h1);
        repeat (20) tick();
        check("held-rst no repeat", 32'(win_sel), 32'h1);
        btn_win = 1'b0;
        repeat (10) tick();
        check("held-rst after release", 32'(win_sel), 32'h1);
        check("held-rst led", 32'(led), 32'h00);

        do_reset();
        check("reset2 win_sel", 32'(win_sel), 32'h0);
        check("reset2 mode", 32'(mode), 32'h0);

        run_range(n_a, n_b);

        // Heartbeat bit on led[7] must flip every 8 cycles in HEART mode.
        prev_hb = led[7];
        since   = 0;
        toggles = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            since++;
            if (led[7] !== prev_hb) begin
                if (toggles > 0) check("hb period", 32'(since), 32'd8);
                toggles++;
                since   = 0;
                prev_hb = led[7];
            end
            check("hb low bits", 32'(led[6:0]), 32'h7F);
        end
        check("hb toggles seen", 32'(toggles >= 4), 32'h1);

        run_range(n_b, vq.size());

        // Narrow 12-bit status: top window is zero-padded, window index wraps at 2.
        do_reset();
        check("narrow reset led", 32'(led2), 32'h00);
        status_in = 32'h00000ABC; status_valid = 1'b1;
        tick();
        status_valid = 1'b0;
        tick();
        check("narrow win0 led", 32'(led2), 32'hBC);
        btn_win = 1'b1; repeat (10) tick();
        btn_win = 1'b0; repeat (10) tick();
        check("narrow win1 sel", 32'(win_sel2), 32'h1);
        check("narrow win1 led", 32'(led2), 32'h0A);
        btn_win = 1'b1; repeat (10) tick();
        btn_win = 1'b0; repeat (10) tick();
        check("narrow wrap sel", 32'(win_sel2), 32'h0);
        check("narrow wrap led", 32'(led2), 32'hBC);
        check("narrow mode", 32'(mode2), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
